// File: rtl/m31_pkg.sv
// Shared Mersenne-31 field definitions: element type, modulus, the
// inversion exponent, the inverter FSM state encoding and a helper
// that folds a 62-bit product back into a canonical field element.
package m31_pkg;

    typedef logic [30:0] m31_t;

    // Field modulus 2^31 - 1.
    localparam m31_t P_M31 = 31'h7FFFFFFF;

    // Fermat exponent P_M31 - 2. Bit 30 seeds acc, bit 1 is the only clear bit.
    localparam m31_t M31_INV_EXP = 31'h7FFFFFFD;

    // Starting bit of the square-and-multiply scan (bit 30 is the seed).
    localparam logic [4:0] M31_INV_TOP_BIT = 5'd29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } m31_inv_state_e;

    // Fold a product of two canonical elements: 2^31 == 1 mod P, so
    // add high and low halves, fold the carry once more, and map P to 0.
    function automatic m31_t m31_reduce(input logic [61:0] p);
        logic [31:0] s;
        m31_t        t;
        s = {1'b0, p[61:31]} + {1'b0, p[30:0]};
        t = s[30:0] + {30'b0, s[31]};
        return (t == P_M31) ? '0 : t;
    endfunction

    // Map the non-canonical encoding of zero onto zero.
    function automatic m31_t m31_canon(input m31_t x);
        return (x == P_M31) ? '0 : x;
    endfunction

endpackage

// File: rtl/m31_mul.sv
// Fixed-latency modular multiplier over GF(2^31 - 1).
// Stage 1 registers the raw 62-bit product; the reduction runs in the
// following cycle and LAT-1 further registers carry the reduced result,
// so p_o reflects operands driven LAT cycles earlier. No valid tracking:
// the caller knows when to sample.
module m31_mul
    import m31_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  m31_t a_i,
    input  m31_t b_i,
    output m31_t p_o
);

    logic [61:0] prod_reg;
    m31_t        red;

    // First pipeline stage: raw product of the two canonical operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_reg <= '0;
        end else begin
            prod_reg <= {31'b0, a_i} * {31'b0, b_i};
        end
    end

    assign red = m31_reduce(prod_reg);

    generate
        if (LAT == 1) begin : g_lat1
            assign p_o = red;
        end else begin : g_pipe
            m31_t stage_reg [0:LAT-2];

            for (genvar gi = 0; gi < LAT - 1; gi++) begin : g_stage
                // Delay stage gi of the reduced result.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        stage_reg[gi] <= '0;
                    end else if (gi == 0) begin
                        stage_reg[gi] <= red;
                    end else begin
                        stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end

            assign p_o = stage_reg[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/m31_inv.sv
// Multiplicative inverse over GF(2^31 - 1) by Fermat: x^(P-2), computed
// left-to-right with one shared m31_mul. 30 squares plus 29 multiplies,
// each taking MUL_LAT+1 cycles (issue + MUL_LAT waits). The accept edge
// only registers the raw operand; the following cycle canonicalises it
// and seeds acc, keeping the P_M31 compare off the input-port path.
// Optional feature: `M31_INV_ZERO_FLAG_EN adds the zero_o output.
module m31_inv
    import m31_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  m31_t a_i,
    output logic out_valid,
    input  logic out_ready,
    output m31_t res_o
`ifdef M31_INV_ZERO_FLAG_EN
    ,
    output logic zero_o
`endif
);

    localparam int              CW       = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0]   CYC_LAST = CW'(MUL_LAT);

    m31_inv_state_e state_reg, state_next;

    logic [4:0]    bit_reg;
    logic [CW-1:0] cyc_reg;
    logic          seed_reg;
    m31_t          raw_reg;
    m31_t          x_reg;
    m31_t          acc_reg;
    m31_t          res_reg;
`ifdef M31_INV_ZERO_FLAG_EN
    logic          zero_reg;
`endif

    logic  accept;
    logic  in_op;
    logic  op_done;
    logic  exp_bit;
    logic  last_bit;
    m31_t  mul_b;
    m31_t  mul_p;

    assign in_op    = (state_reg == SQR) || (state_reg == MUL);
    assign op_done  = in_op && !seed_reg && (cyc_reg == CYC_LAST);
    assign exp_bit  = M31_INV_EXP[bit_reg];
    assign last_bit = (bit_reg == 5'd0);
    assign accept   = in_valid && in_ready;

    // Squares use acc for both operands; multiplies bring in x.
    assign mul_b = (state_reg == MUL) ? x_reg : acc_reg;

    m31_mul #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (acc_reg),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_next = SQR;
                end
            end
            SQR: begin
                if (op_done) begin
                    if (exp_bit) begin
                        state_next = MUL;
                    end else if (last_bit) begin
                        state_next = DONE;
                    end else begin
                        state_next = SQR;
                    end
                end
            end
            MUL: begin
                if (op_done) begin
                    state_next = last_bit ? DONE : SQR;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, seeding and per-operation cycle timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_reg  <= '0;
            x_reg    <= '0;
            seed_reg <= 1'b0;
            cyc_reg  <= '0;
        end else begin
            seed_reg <= accept;
            if (accept) begin
                raw_reg <= a_i;
                cyc_reg <= '0;
            end else if (in_op && !seed_reg) begin
                cyc_reg <= op_done ? '0 : cyc_reg + CW'(1);
            end
            if (seed_reg) begin
                x_reg <= m31_canon(raw_reg);
            end
        end
    end

    // Accumulator and exponent bit pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            bit_reg <= '0;
        end else begin
            if (accept) begin
                bit_reg <= M31_INV_TOP_BIT;
            end else if (op_done && !last_bit && ((state_reg == MUL) || !exp_bit)) begin
                bit_reg <= bit_reg - 5'd1;
            end
            if (seed_reg) begin
                acc_reg <= m31_canon(raw_reg);
            end else if (op_done) begin
                acc_reg <= mul_p;
            end
        end
    end

    // Result register, loaded as the final operation completes and held
    // through DONE regardless of out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_reg <= '0;
        end else if (op_done && (state_next == DONE)) begin
            res_reg <= mul_p;
        end
    end

    assign res_o = res_reg;

`ifdef M31_INV_ZERO_FLAG_EN
    // Zero flag decided from the raw operand during the seed cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
        end else if (seed_reg) begin
            zero_reg <= (m31_canon(raw_reg) == '0);
        end
    end

    assign zero_o = zero_reg;
`endif

endmodule

// File: tb/tb_m31_inv.sv
// Directed bench for m31_inv at MUL_LAT = 4: latency, known inverses,
// zero handling, output stall, and reset during an operation.
module tb_m31_inv;

    localparam int MUL_LAT = 4;
    localparam int EXP_LAT = 296;   // 1 + 59 * (4 + 1), hand-computed

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] a_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [30:0] res_o;
`ifdef M31_INV_ZERO_FLAG_EN
    logic        zero_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m31_inv #(
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_o     (res_o)
`ifdef M31_INV_ZERO_FLAG_EN
        ,
        .zero_o    (zero_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin
            tick();
            n = n + 1;
        end
    endtask

    // One full transaction with out_ready already high.
    task automatic run_op(input string tag, input logic [30:0] a, input logic [30:0] r);
        int n;
        chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a_i      = a;
        tick();
        in_valid = 1'b0;
        a_i      = 31'($urandom);
        wait_valid(n);
        chk({tag, " latency"}, n, EXP_LAT);
        chk({tag, " res"}, {1'b0, res_o}, {1'b0, r});
`ifdef M31_INV_ZERO_FLAG_EN
        chk({tag, " zero"}, {31'b0, zero_o}, {31'b0, (a == 31'h0) || (a == 31'h7FFFFFFF)});
`endif
        $display("op %s: a=0x%08h res=0x%08h latency=%0d", tag, a, res_o, n);
        tick();
        chk({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " in_ready back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int bad;

        // Reset state.
        tick(); tick(); tick();
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst res", {1'b0, res_o}, 32'd0);
`ifdef M31_INV_ZERO_FLAG_EN
        chk("rst zero", {31'b0, zero_o}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", {31'b0, in_ready}, 32'd1);

        // Known inverses.
        run_op("inv1", 31'h00000001, 31'h00000001);
        run_op("inv2", 31'h00000002, 31'h40000000);
        run_op("inv3", 31'h00000003, 31'h55555555);
        run_op("invm1", 31'h7FFFFFFE, 31'h7FFFFFFE);
        run_op("inv4", 31'h00000004, 31'h20000000);
        run_op("inv2p30", 31'h40000000, 31'h00000002);

        // Both encodings of zero.
        run_op("zero", 31'h00000000, 31'h00000000);
        run_op("zeroP", 31'h7FFFFFFF, 31'h00000000);

        // Output stall: hold out_ready low 20 cycles while in_valid keeps offering.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_i       = 31'h00000003;
        tick();
        a_i = 31'h00001234;
        wait_valid(n);
        chk("stall latency", n, EXP_LAT);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || res_o !== 31'h55555555 || in_ready !== 1'b0) begin
                bad = bad + 1;
            end
            tick();
        end
        chk("stall hold violations", bad, 0);
        chk("stall res", {1'b0, res_o}, 32'h55555555);
        out_ready = 1'b1;
        tick();
        chk("stall release out_valid", {31'b0, out_valid}, 32'd0);
        chk("stall release in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        $display("op stall: res=0x%08h held 20 cycles, violations=%0d", 31'h55555555, bad);

        // Reset 100 cycles into an operation.
        in_valid = 1'b1;
        a_i      = 31'h00000005;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("midop busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick(); tick();
        chk("midop rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("midop rst out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midop post rst in_ready", {31'b0, in_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            if (out_valid !== 1'b0) begin
                bad = bad + 1;
            end
            tick();
        end
        chk("midop no result", bad, 0);
        $display("op midreset: aborted at cycle 100, spurious out_valid cycles=%0d", bad);
        run_op("after_rst", 31'h00000002, 31'h40000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
